// File: rtl/pipe_decoder.sv
// Registered instruction decoder with a valid/ready input, a DEPTH-entry output FIFO,
// a flush for redirects and a saturating count of illegal instructions accepted.
module pipe_decoder #(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned PC_W     = 32,
    parameter int unsigned ALU_OP_W = 5,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    input  logic [PC_W-1:0]     in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PC_W-1:0]     out_pc,
    output logic [ALU_OP_W-1:0] out_alu_op,
    output logic [8:0]          out_flags,
    output logic [4:0]          out_rs,
    output logic [4:0]          out_rt,
    output logic [4:0]          out_rd,
    output logic [4:0]          out_shamt,
    output logic [15:0]         out_imm,
    output logic [25:0]         out_target,
    output logic [CNT_W-1:0]    illegal_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    // Entry layout: {pc, alu_op, flags, instr[25:0]}; all register/imm fields come from instr[25:0].
    localparam int unsigned EW = PC_W + ALU_OP_W + 9 + 26;

    logic [AW:0]        wr_ptr_q, rd_ptr_q;
    logic [EW-1:0]      mem_q [DEPTH];
    logic [CNT_W-1:0]   cnt_q;
    logic [ALU_OP_W-1:0] dec_alu;
    logic [8:0]         dec_flags;
    logic [5:0]         op, funct;
    logic               full, empty, push, pop;
    logic [EW-1:0]      head;

    assign op    = in_instr[31:26];
    assign funct = in_instr[5:0];

    // Decode op/funct into alu_op and one-hot flags; anything unlisted is illegal.
    always_comb begin
        dec_alu   = '0;
        dec_flags = '0;
        case (op)
            6'b000000: begin
                case (funct)
                    6'b100000: begin dec_flags[0] = 1'b1; dec_alu = ALU_OP_W'(0); end
                    6'b100010: begin dec_flags[0] = 1'b1; dec_alu = ALU_OP_W'(1); end
                    6'b100100: begin dec_flags[0] = 1'b1; dec_alu = ALU_OP_W'(2); end
                    6'b100101: begin dec_flags[0] = 1'b1; dec_alu = ALU_OP_W'(3); end
                    6'b100110: begin dec_flags[0] = 1'b1; dec_alu = ALU_OP_W'(4); end
                    6'b000000: begin dec_flags[1] = 1'b1; dec_alu = ALU_OP_W'(5); end
                    6'b001010: begin dec_flags[2] = 1'b1; dec_alu = ALU_OP_W'(6); end
                    default:   dec_flags[8] = 1'b1;
                endcase
            end
            6'b100011: dec_flags[3] = 1'b1;
            6'b101011: dec_flags[4] = 1'b1;
            6'b000010: dec_flags[7] = 1'b1;
            6'b111110: begin dec_flags[5] = 1'b1; dec_alu = ALU_OP_W'(1); end
            6'b111111: begin dec_flags[6] = 1'b1; dec_alu = ALU_OP_W'(2); end
            default:   dec_flags[8] = 1'b1;
        endcase
    end

    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    // A push offered during flush is dropped, so it is neither stored nor counted.
    assign push  = in_valid && !full && !flush;
    assign pop   = out_ready && !empty && !flush;

    // FIFO pointers, storage and illegal counter; reset clears storage so outputs read 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) begin
                    mem_q[wr_ptr_q[AW-1:0]] <= {in_pc, dec_alu, dec_flags, in_instr[25:0]};
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
            end
            if (push && dec_flags[8] && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Present the head entry; when empty this is a stale slot and must be ignored.
    always_comb begin
        head       = mem_q[rd_ptr_q[AW-1:0]];
        out_pc     = head[EW-1 -: PC_W];
        out_alu_op = head[35 +: ALU_OP_W];
        out_flags  = head[34:26];
        out_target = head[25:0];
        out_rs     = head[25:21];
        out_rt     = head[20:16];
        out_rd     = head[15:11];
        out_shamt  = head[10:6];
        out_imm    = head[15:0];
    end

    assign in_ready    = !full;
    assign out_valid   = !empty;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_decoder.sv
// Randomised scoreboard bench for pipe_decoder: a table-driven reference decoder feeds an
// expected-entry queue that a negedge monitor pops whenever the DUT presents a head entry.
module tb_pipe_decoder;

    localparam int DEPTH    = 2;
    localparam int PC_W     = 32;
    localparam int ALU_OP_W = 5;
    localparam int CNT_W    = 16;

    // Reference decode tables: R-type funct codes, then I/J-type opcodes.
    localparam logic [5:0] R_FUNCT [7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                           6'b100110, 6'b000000, 6'b001010};
    localparam int         R_ALU   [7] = '{0, 1, 2, 3, 4, 5, 6};
    localparam int         R_FLAG  [7] = '{0, 0, 0, 0, 0, 1, 2};
    localparam logic [5:0] I_OP    [5] = '{6'b100011, 6'b101011, 6'b000010, 6'b111110, 6'b111111};
    localparam int         I_ALU   [5] = '{0, 0, 0, 1, 2};
    localparam int         I_FLAG  [5] = '{3, 4, 7, 5, 6};

    logic                clk = 1'b0;
    logic                rst, flush, in_valid, out_ready;
    logic [31:0]         in_instr;
    logic [PC_W-1:0]     in_pc;
    logic                in_ready, out_valid;
    logic [PC_W-1:0]     out_pc;
    logic [ALU_OP_W-1:0] out_alu_op;
    logic [8:0]          out_flags;
    logic [4:0]          out_rs, out_rt, out_rd, out_shamt;
    logic [15:0]         out_imm;
    logic [25:0]         out_target;
    logic [CNT_W-1:0]    illegal_cnt;

    // Second instance with a 2-bit counter, used only to observe saturation.
    logic                s_in_ready, s_out_valid;
    logic [PC_W-1:0]     s_out_pc;
    logic [ALU_OP_W-1:0] s_out_alu_op;
    logic [8:0]          s_out_flags;
    logic [4:0]          s_out_rs, s_out_rt, s_out_rd, s_out_shamt;
    logic [15:0]         s_out_imm;
    logic [25:0]         s_out_target;
    logic [1:0]          s_illegal_cnt;

    always #5 clk = ~clk;

    pipe_decoder #(.DEPTH(DEPTH), .PC_W(PC_W), .ALU_OP_W(ALU_OP_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_alu_op(out_alu_op), .out_flags(out_flags), .out_rs(out_rs),
        .out_rt(out_rt), .out_rd(out_rd), .out_shamt(out_shamt), .out_imm(out_imm),
        .out_target(out_target), .illegal_cnt(illegal_cnt)
    );

    pipe_decoder #(.DEPTH(DEPTH), .PC_W(PC_W), .ALU_OP_W(ALU_OP_W), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_pc(s_out_pc), .out_alu_op(s_out_alu_op), .out_flags(s_out_flags),
        .out_rs(s_out_rs), .out_rt(s_out_rt), .out_rd(s_out_rd), .out_shamt(s_out_shamt),
        .out_imm(s_out_imm), .out_target(s_out_target), .illegal_cnt(s_illegal_cnt)
    );

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [4:0]      alu;
        logic [8:0]      flags;
        logic [31:0]     instr;
    } exp_t;

    exp_t        exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int unsigned cnt_model = 0;
    int unsigned sat_model = 0;
    bit          model_on = 1'b0;
    bit          check_zero = 1'b0;
    logic [PC_W-1:0] pc_ctr = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic void ref_decode(input logic [31:0] ins, output logic [4:0] alu,
                                       output logic [8:0] fl);
        int bitpos;
        bitpos = 8;
        alu    = '0;
        if (ins[31:26] == 6'b000000) begin
            for (int i = 0; i < 7; i++) begin
                if (ins[5:0] == R_FUNCT[i]) begin
                    alu    = 5'(R_ALU[i]);
                    bitpos = R_FLAG[i];
                end
            end
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (ins[31:26] == I_OP[i]) begin
                    alu    = 5'(I_ALU[i]);
                    bitpos = I_FLAG[i];
                end
            end
        end
        fl = 9'(1) << bitpos;
    endfunction

    function automatic logic [107:0] expected_payload(input exp_t e);
        return {e.pc, e.alu, e.flags, e.instr[25:21], e.instr[20:16], e.instr[15:11],
                e.instr[10:6], e.instr[15:0], e.instr[25:0]};
    endfunction

    logic [107:0] dut_payload;
    assign dut_payload = {out_pc, out_alu_op, out_flags, out_rs, out_rt, out_rd, out_shamt,
                          out_imm, out_target};

    // Monitor/scoreboard: compare current state, then apply this cycle's handshakes.
    always @(negedge clk) begin
        exp_t e;
        bit   accept;
        if (rst) begin
            exp_q.delete();
            cnt_model  = 0;
            sat_model  = 0;
            model_on   = 1'b1;
            check_zero = 1'b1;
        end else if (model_on) begin
            if (check_zero) begin
                check("reset_payload", 128'(dut_payload), 128'(0));
                check_zero = 1'b0;
            end
            check("in_ready", 128'(in_ready), 128'(exp_q.size() < DEPTH));
            check("out_valid", 128'(out_valid), 128'(exp_q.size() > 0));
            check("illegal_cnt", 128'(illegal_cnt), 128'(cnt_model));
            check("illegal_cnt_sat", 128'(s_illegal_cnt), 128'(sat_model));
            accept = in_valid && (exp_q.size() < DEPTH) && !flush;
            if (flush) begin
                exp_q.delete();
            end else if (out_ready && exp_q.size() > 0) begin
                check("payload", 128'(dut_payload), 128'(expected_payload(exp_q[0])));
                void'(exp_q.pop_front());
            end
            if (accept) begin
                e.pc    = in_pc;
                e.instr = in_instr;
                ref_decode(in_instr, e.alu, e.flags);
                exp_q.push_back(e);
                if (e.flags[8]) begin
                    if (cnt_model < (2 ** CNT_W) - 1) cnt_model++;
                    if (sat_model < 3) sat_model++;
                end
            end
        end
    end

    function automatic logic [31:0] mk(input logic [5:0] o, input logic [5:0] f);
        logic [31:0] r;
        r = $urandom();
        return {o, r[19:0], f};
    endfunction

    task automatic drive(input bit v, input logic [31:0] ins, input bit ordy, input bit fl);
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc_ctr;
        pc_ctr    = pc_ctr + 4;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] seq [11];

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single ADD through an otherwise idle pipe.
        drive(1, mk(6'b000000, 6'b100000), 1, 0);
        drive(0, '0, 1, 0);
        drive(0, '0, 1, 0);

        // Every remaining legal encoding back to back.
        seq = '{mk(6'b000000, 6'b100010), mk(6'b000000, 6'b100100), mk(6'b000000, 6'b100101),
                mk(6'b000000, 6'b100110), mk(6'b000000, 6'b000000), mk(6'b000000, 6'b001010),
                mk(6'b100011, 6'b000001), mk(6'b101011, 6'b000010), mk(6'b000010, 6'b111111),
                mk(6'b111110, 6'b010101), mk(6'b111111, 6'b100000)};
        foreach (seq[i]) drive(1, seq[i], 1, 0);
        repeat (3) drive(0, '0, 1, 0);

        // Fill with consumer stalled, offer one more, then pop while full, then push+pop.
        for (int i = 0; i < DEPTH + 1; i++) drive(1, mk(6'b000000, 6'b100000), 0, 0);
        drive(1, mk(6'b100011, 6'b0), 1, 0);
        repeat (4) drive(1, mk(6'b101011, 6'b0), 1, 0);
        repeat (3) drive(0, '0, 1, 0);

        // Illegal opcode and illegal funct, then enough more to saturate the 2-bit counter.
        drive(1, mk(6'b010101, 6'b100000), 1, 0);
        drive(1, mk(6'b000000, 6'b111111), 1, 0);
        repeat (4) drive(1, mk(6'b010101, 6'b000000), 1, 0);
        repeat (2) drive(0, '0, 1, 0);

        // Flush a full FIFO while an illegal push is offered.
        for (int i = 0; i < DEPTH; i++) drive(1, mk(6'b111110, 6'b0), 0, 0);
        drive(1, mk(6'b010101, 6'b0), 0, 1);
        drive(0, '0, 0, 0);
        drive(1, mk(6'b111111, 6'b0), 1, 0);
        drive(0, '0, 1, 0);

        // Reset with the FIFO half full.
        for (int i = 0; i < DEPTH / 2; i++) drive(1, mk(6'b000000, 6'b100110), 0, 0);
        rst = 1'b1;
        drive(1, mk(6'b010101, 6'b0), 0, 0);
        rst = 1'b0;
        drive(0, '0, 0, 0);

        // Random traffic with occasional flush and reset.
        for (int n = 0; n < 800; n++) begin
            logic [31:0] ins;
            int          pick;
            pick = int'($urandom_range(0, 15));
            if (pick < 7) begin
                ins = mk(6'b000000, R_FUNCT[pick]);
            end else if (pick < 12) begin
                ins = mk(I_OP[pick - 7], 6'(pick));
            end else begin
                ins = $urandom();
            end
            rst = ($urandom_range(0, 199) == 0);
            drive($urandom_range(0, 3) != 0, ins, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 39) == 0);
            rst = 1'b0;
        end

        repeat (DEPTH + 4) drive(0, '0, 1, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
